// File: rtl/nr_fetch_pkg.sv
// Shared types and default sizing for the nanoRisk fetch unit.
// The state enum is visible to every file that imports this package.
package nr_fetch_pkg;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_PC_STEP  = 1;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // free to issue a request
    S_WAIT = 2'd1,  // request outstanding, response will be kept
    S_DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

endpackage

// File: rtl/nr_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// and the decode-side valid/ready output.
interface nr_fetch_if
  import nr_fetch_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          redir;
  logic [AW-1:0] redir_pc;

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;

  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  // Fetch-unit side
  modport master (
    input  redir, redir_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc
  );

  // Environment side: flow control, instruction memory and decode
  modport slave (
    output redir, redir_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/nr_pc_reg.sv
// Program-counter register: a redirect load takes priority over the
// post-request increment, which wraps modulo 2^AW.
module nr_pc_reg
  import nr_fetch_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_pc,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  localparam logic [AW-1:0] STEP   = AW'(PC_STEP);
  localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RST;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/nr_fetch_unit.sv
// nanoRisk fetch sequencer: single-outstanding instruction-memory requests,
// one-entry output buffer to decode, wrong-path responses dropped after redirect.
module nr_fetch_unit
  import nr_fetch_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic       clk,
  input  logic       rst_n,
  nr_fetch_if.master bus
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc;
  logic [AW-1:0] pend_pc_q;
  logic          inst_valid_q;
  logic [DW-1:0] inst_data_q;
  logic [AW-1:0] inst_pc_q;

  logic req_valid;
  logic req_fire;
  logic capture;

  // Requests go out only when the buffer is empty or draining, so a
  // response can always be captured; rst_n keeps the request low in reset.
  assign req_valid = rst_n && (state_q == S_REQ) && (!inst_valid_q || bus.inst_ready)
                     && !bus.redir;
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign capture   = (state_q == S_WAIT) && bus.imem_rsp_valid && !bus.redir;

  nr_pc_reg #(
    .AW       (AW),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (bus.redir),
    .load_pc (bus.redir_pc),
    .inc     (req_fire),
    .pc      (pc)
  );

  // NOTE: state_d is assigned before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rsp_valid) state_d = S_REQ;
        else if (bus.redir)     state_d = S_DROP;
      end
      S_DROP:  if (bus.imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) pend_pc_q <= pc;
    end
  end

  // Redirect flushes the buffer; a capture overrides a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else if (bus.redir) begin
      inst_valid_q <= 1'b0;
    end else if (capture) begin
      inst_valid_q <= 1'b1;
      inst_data_q  <= bus.imem_rsp_data;
      inst_pc_q    <= pend_pc_q;
    end else if (inst_valid_q && bus.inst_ready) begin
      inst_valid_q <= 1'b0;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;

  // A response with nothing outstanding is a memory protocol violation.
  rsp_without_req_a: assert property (
    @(posedge clk) disable iff (!rst_n) !((state_q == S_REQ) && bus.imem_rsp_valid)
  );

endmodule

// File: doc/nr_fetch_unit.md
Name: nr_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the nanoRisk core.
- Consumes the flow-control select (branch|jump) plus its target PC.
- Issues single-outstanding requests to instruction memory and delivers fetched instructions with their PC to decode over a valid/ready interface.
- Discards wrong-path responses after a redirect.

Parameters:
- AW, 8, PC/address width in bits.
- DW, 8, instruction width in bits.
- PC_STEP, 1, PC increment per fetch (modulo 2^AW).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redir  input  1  flow-control select (branch|jump taken); single-cycle pulse or level.
- redir_pc  input  AW  redirect target, sampled when redir=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  AW  fetch address (= current PC).
- imem_rsp_valid  input  1  response valid; at most one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  input  DW  fetched instruction.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst_data  output  DW  instruction word.
- inst_pc  output  AW  address of inst_data.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=S_REQ, drop=0.
  - inst_valid=0, inst_data=0, inst_pc=0, imem_req_valid=0.
- States:
  - S_REQ: may issue a request.
  - S_WAIT: one request outstanding, response will be kept.
  - S_DROP: one request outstanding, response will be discarded.
- imem_req_valid = (state==S_REQ) & (!inst_valid | inst_ready) & !redir. imem_addr = pc.
- Request handshake (valid & ready):
  - pc <= pc+PC_STEP, wrapping mod 2^AW.
  - Latch request address into pend_pc; go to S_WAIT.
- S_WAIT with imem_rsp_valid and no redir:
  - inst_data <= rsp_data, inst_pc <= pend_pc, inst_valid <= 1 (registered).
  - Go to S_REQ.
  - Latency: response cycle T gives inst_valid at T+1.
- Output handshake (inst_valid & inst_ready) with no new capture: inst_valid <= 0.
- Capture and drain in the same cycle: new instruction replaces the old one and inst_valid stays 1. Back-to-back throughput is one instruction per memory round trip.
- Output buffer holds one entry and never overflows, because a request issues only when the buffer is empty or draining.
- Redirect (redir=1), every state:
  - pc <= redir_pc; inst_valid <= 0 (flush; same-cycle consumer handshake still counts as taken).
  - S_REQ: no request issued this cycle (suppressed); stay in S_REQ.
  - S_WAIT without rsp_valid: go to S_DROP.
  - S_WAIT with rsp_valid the same cycle: response discarded; go to S_REQ.
  - S_DROP: pc updated again; stay in S_DROP (last target wins).
- S_DROP with imem_rsp_valid: response discarded, no output change; go to S_REQ. Any redir that cycle updates pc.
- imem_rsp_valid in S_REQ is illegal. Ignore it; add a simulation assertion.
- imem_req_valid, once asserted, is held with a stable address until accepted, unless redir or a stalled output (!inst_ready while inst_valid) drops it. Memory is therefore required to tolerate request withdrawal.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight response is the memory's responsibility and is ignored in S_REQ.

Decomposition:
- Package nr_fetch_pkg holds:
  - state enum (S_REQ, S_WAIT, S_DROP, 2 bits);
  - default AW, DW, PC_STEP, RESET_PC constants.
- One natural sub-module: nr_pc_reg, the PC register with async reset, load (redir), and increment (request accepted), with load priority over increment.
- FSM and output buffer stay in the top module.

Test Plan:
- Reset release, memory ready, rsp 1 cycle after acceptance, inst_ready=1 → requests to addresses 0x00, 0x01, 0x02; inst_pc 0x00/0x01/0x02 with matching data; inst_valid at acceptance+2.
- pc=0xFF, request accepted → next imem_addr=0x00 (wrap).
- redir=1, redir_pc=0x40 while in S_WAIT, response 2 cycles later → response dropped, inst_valid stays 0; next request address 0x40.
- redir=1 (target 0x10) in the same cycle as imem_rsp_valid in S_WAIT → data discarded, inst_valid=0; next cycle request to 0x10.
- inst_ready=0 with inst_valid=1 → imem_req_valid=0 and inst_data/inst_pc stable for 5 cycles; inst_ready=1 → drain and request resumes in that cycle.
- rst_n pulsed low mid-S_WAIT → outputs zero asynchronously; after release first request address = RESET_PC.
